// File: rtl/drive_mode_arbiter.sv
// Motor command arbiter: selects manual or auto source, forces STOP through mode
// changes and estop, runs a per-source command watchdog and slew-limits speed increases.
//
// state  | meaning
// IDLE   | post-reset, heads straight into SWITCH
// MANUAL | outputs follow the manual target
// AUTO   | outputs follow the auto target
// SWITCH | STOP held for STOP_HOLD_CYCLES, then enter the selected mode
// FAULT  | auto watchdog tripped, STOP held until manual is requested
// ESTOP  | emergency stop active, STOP held
module drive_mode_arbiter #(
    parameter int unsigned STOP_HOLD_CYCLES = 1000,
    parameter int unsigned WATCHDOG_CYCLES  = 5000000,
    parameter int unsigned RAMP_CYCLES      = 500000,
    parameter logic [3:0]  STOP_CMD         = 4'b1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_sel,
    input  logic       estop,
    input  logic       man_valid,
    input  logic [3:0] man_cmd,
    input  logic [3:0] man_speed,
    input  logic       auto_valid,
    input  logic [3:0] auto_cmd,
    input  logic [3:0] auto_speed,
    output logic [3:0] move_cmd,
    output logic [3:0] speed_level,
    output logic       active_mode,
    output logic       fault,
    output logic [2:0] state
);

    localparam int HW = (STOP_HOLD_CYCLES > 1) ? $clog2(STOP_HOLD_CYCLES) : 1;
    localparam int WW = $clog2(WATCHDOG_CYCLES);
    localparam int RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_LOAD = HW'(STOP_HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);
    localparam logic [WW-1:0] WD_WARN   = WW'(WATCHDOG_CYCLES - 2);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MANUAL = 3'd1,
        S_AUTO   = 3'd2,
        S_SWITCH = 3'd3,
        S_FAULT  = 3'd4,
        S_ESTOP  = 3'd5
    } state_t;

    state_t cur_state, nxt_state;

    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wd_cnt;
    logic [RW-1:0] ramp_cnt;
    logic [3:0]    tgt_cmd;
    logic [3:0]    tgt_speed;

    logic       run_state;
    logic       mode_change;
    logic       wd_expire;
    logic       src_valid;
    logic [3:0] src_cmd;
    logic [3:0] src_speed;

    assign run_state   = (cur_state == S_MANUAL) || (cur_state == S_AUTO);
    assign mode_change = run_state && (mode_sel != active_mode);
    // Expiry fires once, on the step into WD_LAST; the held count cannot refire it.
    assign wd_expire   = run_state && (wd_cnt == WD_WARN);
    assign src_valid   = active_mode ? auto_valid : man_valid;
    assign src_cmd     = active_mode ? auto_cmd   : man_cmd;
    assign src_speed   = active_mode ? auto_speed : man_speed;

    assign move_cmd = run_state ? tgt_cmd : STOP_CMD;
    assign state    = cur_state;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (estop) begin
            nxt_state = S_ESTOP;
        end else begin
            case (cur_state)
                S_IDLE:   nxt_state = S_SWITCH;
                S_MANUAL,
                S_AUTO: begin
                    if (mode_change)
                        nxt_state = S_SWITCH;
                    else if (wd_expire && (cur_state == S_AUTO))
                        nxt_state = S_FAULT;
                end
                S_SWITCH: if (hold_cnt == '0) nxt_state = mode_sel ? S_AUTO : S_MANUAL;
                S_FAULT:  if (!mode_sel) nxt_state = S_SWITCH;
                S_ESTOP:  nxt_state = S_SWITCH;
                default:  nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt    <= '0;
            wd_cnt      <= '0;
            ramp_cnt    <= '0;
            tgt_cmd     <= STOP_CMD;
            tgt_speed   <= 4'd0;
            speed_level <= 4'd0;
            active_mode <= 1'b0;
            fault       <= 1'b0;
        end else begin
            if ((nxt_state == S_SWITCH) && (cur_state != S_SWITCH))
                hold_cnt <= HOLD_LOAD;
            else if ((cur_state == S_SWITCH) && (hold_cnt != '0))
                hold_cnt <= hold_cnt - HW'(1);

            if ((cur_state == S_SWITCH) && ((nxt_state == S_MANUAL) || (nxt_state == S_AUTO)))
                active_mode <= mode_sel;

            if ((cur_state == S_AUTO) && (nxt_state == S_FAULT))
                fault <= 1'b1;
            else if ((nxt_state == S_MANUAL) && (cur_state != S_MANUAL))
                fault <= 1'b0;

            if (run_state && (nxt_state == cur_state)) begin
                if (wd_expire) begin
                    tgt_cmd   <= STOP_CMD;
                    tgt_speed <= 4'd0;
                    wd_cnt    <= wd_cnt + WW'(1);
                end else if (src_valid) begin
                    tgt_cmd   <= src_cmd;
                    tgt_speed <= src_speed;
                    wd_cnt    <= '0;
                end else if (wd_cnt != WD_LAST) begin
                    wd_cnt <= wd_cnt + WW'(1);
                end

                if (tgt_speed <= speed_level) begin
                    speed_level <= tgt_speed;
                    ramp_cnt    <= '0;
                end else if (ramp_cnt == RAMP_LAST) begin
                    speed_level <= speed_level + 4'd1;
                    ramp_cnt    <= '0;
                end else begin
                    ramp_cnt <= ramp_cnt + RW'(1);
                end
            end else begin
                // Any non-running cycle, or the cycle leaving a running state, parks at STOP.
                tgt_cmd     <= STOP_CMD;
                tgt_speed   <= 4'd0;
                speed_level <= 4'd0;
                wd_cnt      <= '0;
                ramp_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Directed bench for drive_mode_arbiter: a per-cycle vector table for power-up and
// the manual/auto basics, then hand sequences for watchdog, fault, estop and reset.
module tb_drive_mode_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_sel;
    logic       estop;
    logic       man_valid;
    logic [3:0] man_cmd;
    logic [3:0] man_speed;
    logic       auto_valid;
    logic [3:0] auto_cmd;
    logic [3:0] auto_speed;
    logic [3:0] move_cmd;
    logic [3:0] speed_level;
    logic       active_mode;
    logic       fault;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    drive_mode_arbiter #(
        .STOP_HOLD_CYCLES(4),
        .WATCHDOG_CYCLES (20),
        .RAMP_CYCLES     (3),
        .STOP_CMD        (4'b1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_sel   (mode_sel),
        .estop      (estop),
        .man_valid  (man_valid),
        .man_cmd    (man_cmd),
        .man_speed  (man_speed),
        .auto_valid (auto_valid),
        .auto_cmd   (auto_cmd),
        .auto_speed (auto_speed),
        .move_cmd   (move_cmd),
        .speed_level(speed_level),
        .active_mode(active_mode),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ms;
        logic       mv;
        logic [3:0] mc;
        logic [3:0] msp;
        logic       av;
        logic [3:0] ac;
        logic [3:0] asp;
        logic [3:0] e_move;
        logic [3:0] e_speed;
        logic [2:0] e_state;
        logic       e_mode;
        logic       e_fault;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ms, input logic mv, input logic [3:0] mc,
                                input logic [3:0] msp, input logic av, input logic [3:0] ac,
                                input logic [3:0] asp, input logic [3:0] em, input logic [3:0] es,
                                input logic [2:0] est, input logic emd, input logic ef);
        vec_t v;
        v = '{ms, mv, mc, msp, av, ac, asp, em, es, est, emd, ef};
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input int st, input int mv, input int sp,
                              input int md, input int ft);
        check({tag, " state"},       int'(state),       st);
        check({tag, " move_cmd"},    int'(move_cmd),    mv);
        check({tag, " speed_level"}, int'(speed_level), sp);
        check({tag, " active_mode"}, int'(active_mode), md);
        check({tag, " fault"},       int'(fault),       ft);
    endtask

    initial begin
        int k;

        //               ms mv mc msp av ac asp  mv sp st md f
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0, 0);
        vecs[5]  = mk(0, 1, 1, 3, 0, 0, 0, 1, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0);
        vecs[15] = mk(0, 1, 1, 1, 0, 0, 0, 1, 3, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 3, 0, 0);
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 2, 1, 0);
        vecs[22] = mk(1, 1, 2, 5, 0, 0, 0, 8, 0, 2, 1, 0);
        vecs[23] = mk(1, 0, 0, 0, 1, 0, 2, 0, 0, 2, 1, 0);
        vecs[24] = mk(1, 1, 2, 9, 0, 0, 0, 0, 0, 2, 1, 0);
        vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
        vecs[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0);

        reset = 1'b1; mode_sel = 1'b0; estop = 1'b0;
        man_valid = 1'b0; man_cmd = 4'd0; man_speed = 4'd0;
        auto_valid = 1'b0; auto_cmd = 4'd0; auto_speed = 4'd0;
        repeat (3) tick();
        check_outs("reset", 0, 8, 0, 0, 0);

        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            mode_sel   = vecs[i].ms;
            man_valid  = vecs[i].mv;
            man_cmd    = vecs[i].mc;
            man_speed  = vecs[i].msp;
            auto_valid = vecs[i].av;
            auto_cmd   = vecs[i].ac;
            auto_speed = vecs[i].asp;
            tick();
            check_outs($sformatf("v%0d", i), int'(vecs[i].e_state), int'(vecs[i].e_move),
                       int'(vecs[i].e_speed), int'(vecs[i].e_mode), int'(vecs[i].e_fault));
        end
        man_valid = 1'b0; auto_valid = 1'b0;

        // Auto watchdog: strobes every 10 cycles keep it alive, silence trips it after 20.
        for (int s = 0; s < 2; s++) begin
            auto_valid = 1'b1; auto_cmd = 4'd0; auto_speed = 4'd2;
            tick();
            auto_valid = 1'b0;
            repeat (9) tick();
            check("auto_alive state", int'(state), 2);
            check("auto_alive fault", int'(fault), 0);
        end
        auto_valid = 1'b1;
        tick();
        auto_valid = 1'b0;
        k = 1;
        while (!fault && k < 40) begin
            tick();
            k++;
        end
        check("auto_wd delay", k, 20);
        check_outs("auto_wd", 4, 8, 0, 1, 1);
        repeat (5) tick();
        check("fault_hold state", int'(state), 4);
        check("fault_hold fault", int'(fault), 1);
        mode_sel = 1'b0;
        tick();
        check("fault_exit state", int'(state), 3);
        check("fault_exit fault", int'(fault), 1);
        repeat (3) tick();
        check("fault_sw4 state", int'(state), 3);
        tick();
        check_outs("fault_to_man", 1, 8, 0, 0, 0);

        // Manual watchdog: target drops to STOP/0 but the state stays MANUAL.
        man_valid = 1'b1; man_cmd = 4'd1; man_speed = 4'd2;
        tick();
        man_valid = 1'b0;
        check("man_wd move", int'(move_cmd), 1);
        k = 1;
        while (move_cmd != 4'b1000 && k < 40) begin
            tick();
            k++;
        end
        check("man_wd delay", k, 20);
        check("man_wd state", int'(state), 1);
        check("man_wd fault", int'(fault), 0);
        tick();
        check("man_wd speed", int'(speed_level), 0);
        check("man_wd state2", int'(state), 1);
        man_valid = 1'b1; man_cmd = 4'd2; man_speed = 4'd0;
        tick();
        man_valid = 1'b0;
        check("man_after_wd move", int'(move_cmd), 2);

        // Estop mid-ramp in AUTO.
        mode_sel = 1'b1;
        tick();
        check("to_auto state", int'(state), 3);
        repeat (4) tick();
        check("to_auto entered", int'(state), 2);
        auto_valid = 1'b1; auto_cmd = 4'd0; auto_speed = 4'd5;
        tick();
        auto_valid = 1'b0;
        check("ramp move", int'(move_cmd), 0);
        repeat (3) tick();
        check("ramp speed1", int'(speed_level), 1);
        estop = 1'b1;
        tick();
        check_outs("estop", 5, 8, 0, 1, 0);
        auto_valid = 1'b1; auto_cmd = 4'd3; auto_speed = 4'd7;
        tick();
        auto_valid = 1'b0;
        check("estop_ignore move", int'(move_cmd), 8);
        check("estop_ignore state", int'(state), 5);
        estop = 1'b0;
        tick();
        check("estop_rel state", int'(state), 3);
        repeat (3) tick();
        check("estop_rel sw4", int'(state), 3);
        tick();
        check_outs("estop_to_auto", 2, 8, 0, 1, 0);

        // Mode change in the very cycle the auto watchdog expires: no fault.
        repeat (18) tick();
        check("race pre state", int'(state), 2);
        mode_sel = 1'b0;
        tick();
        check("race state", int'(state), 3);
        check("race fault", int'(fault), 0);

        // Reset in the middle of SWITCH.
        reset = 1'b1;
        tick();
        check_outs("mid_reset", 0, 8, 0, 0, 0);
        reset = 1'b0;
        tick();
        check("post_reset state", int'(state), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/drive_mode_arbiter.md
Name: drive_mode_arbiter

Overview:
- Arbitrates motor command between the manual path (keyboard/remote) and the auto path (PID `move_cmd`/`speed_level` pair). Drives the single `move_cmd`/`speed_level` pair sent to the motor UART encoder.
- Sequences mode changes through a forced-stop hold.
- Enforces a command watchdog and an emergency stop.
- Slew-limits speed increases.

Parameters:
- STOP_HOLD_CYCLES, 1000, cycles STOP is held on any mode change or estop release (≥1).
- WATCHDOG_CYCLES, 5000000, max cycles between valid strobes from the active source (≥2).
- RAMP_CYCLES, 500000, cycles per +1 step when speed increases (≥1).
- STOP_CMD, 4'b1000, `move_cmd` code meaning stop.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode_sel  in  1  requested mode: 0 manual, 1 auto
- estop  in  1  emergency stop, level, highest priority
- man_valid  in  1  one-cycle strobe: man_cmd/man_speed valid
- man_cmd  in  4  manual move command (W=0000, WA=0001, WD=0010, others passed through)
- man_speed  in  4  manual speed level
- auto_valid  in  1  one-cycle strobe: auto_cmd/auto_speed valid
- auto_cmd  in  4  auto move command
- auto_speed  in  4  auto speed level
- move_cmd  out  4  arbitrated move command
- speed_level  out  4  arbitrated, slew-limited speed
- active_mode  out  1  mode currently driving outputs (0 manual, 1 auto)
- fault  out  1  auto watchdog tripped
- state  out  3  FSM state (debug)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
- Reset values: state=IDLE, move_cmd=STOP_CMD, speed_level=0, active_mode=0, fault=0. All counters=0, latched targets: cmd=STOP_CMD, speed=0.
- States:
  - IDLE=0 → SWITCH next cycle (hold counter loaded).
  - MANUAL=1, AUTO=2: outputs track latched target of that source.
  - SWITCH=3: STOP held, counts STOP_HOLD_CYCLES.
  - FAULT=4: STOP held.
  - ESTOP=5: STOP held.
- In SWITCH, FAULT, ESTOP and IDLE: move_cmd=STOP_CMD, speed_level=0, target cleared to STOP_CMD/0.
- Priority per cycle, highest first: reset > estop > mode change > watchdog > valid strobe.
- estop=1 in any state → ESTOP next cycle. estop falling → SWITCH.
- MANUAL/AUTO with mode_sel≠active_mode → SWITCH.
- SWITCH:
  - Counter loaded STOP_HOLD_CYCLES-1 on entry; decrements each cycle.
  - At 0, go to MANUAL if mode_sel=0, else AUTO. mode_sel is sampled in that exit cycle.
  - active_mode is updated on that transition.
  - mode_sel toggling during SWITCH does not restart the count.
- Valid strobes:
  - Only the active source's strobe is honoured, and only in MANUAL/AUTO. The other strobe is ignored.
  - Strobe at cycle n → move_cmd updated at n+1; the target speed is latched at n+1.
- Speed slew, applied in MANUAL/AUTO:
  - target ≤ speed_level: speed_level←target next cycle; ramp counter cleared.
  - target > speed_level: ramp counter increments; on reaching RAMP_CYCLES-1, speed_level+1 and counter←0.
  - Saturates at 15. Never overshoots target.
  - A target change mid-ramp keeps the current counter value.
- Watchdog:
  - Counter is cleared on entry to MANUAL/AUTO and on each honoured strobe; otherwise it increments in MANUAL/AUTO.
  - On reaching WATCHDOG_CYCLES-1 in MANUAL: target←STOP_CMD/0 (key released). State stays MANUAL; the counter holds.
  - On reaching WATCHDOG_CYCLES-1 in AUTO: → FAULT, fault=1.
- FAULT exit:
  - Leaves only when mode_sel=0 (→ SWITCH) or on estop.
  - fault stays 1 until entry to MANUAL, then cleared.
- Same-cycle mode change and watchdog expiry: mode change wins, so no fault is raised.
- Reset mid-SWITCH/ramp: all returns to reset values next cycle.

Test Plan:
- Bench parameters: STOP_HOLD_CYCLES=4, WATCHDOG_CYCLES=20, RAMP_CYCLES=3.
- Reset release, mode_sel=0 → IDLE(1 cycle), SWITCH 4 cycles with STOP/0, then state=MANUAL, active_mode=0. man_valid with cmd 0001, speed 3 → move_cmd=0001 next cycle; speed_level 1,2,3 at +3,+6,+9 cycles.
- In MANUAL at speed 3, strobe speed 1 → speed_level=1 next cycle. Toggle mode_sel=1 → STOP/0 for exactly 4 cycles, then AUTO, active_mode=1. man_valid strobes in AUTO → no output change.
- AUTO with auto_valid every 10 cycles → no fault. Stop strobes → FAULT and fault=1 at 20 cycles after last strobe. mode_sel=1 held → stays FAULT. mode_sel=0 → SWITCH(4) → MANUAL, fault=0.
- MANUAL, no strobe for 20 cycles → target STOP/0 applied, state remains MANUAL, fault=0.
- estop asserted mid-ramp in AUTO → ESTOP next cycle, STOP/0. auto_valid ignored. estop released → SWITCH 4 cycles → AUTO.
- Same cycle: AUTO watchdog expiry and mode_sel 1→0 → SWITCH, fault stays 0. reset asserted during SWITCH → reset values next cycle.
